// File: rtl/tt_um_result_buffer_if.sv
// Result-buffer stream bundle.
// Purpose : groups the fill-side input, the valid/ready drain stream and the
//           sticky status flags of tt_um_result_buffer into one interface.
// Signals : in_valid/in_row/in_data   - one result row per cycle from the multiplier
//           out_valid/out_ready       - drain handshake
//           out_data/out_row/out_last - drained element, its row, end-of-frame marker
//           out_argmax                - argmax index of the draining frame
//           clr_flags/ovf/seq_err     - sticky flag clear and the flags themselves
// Modports: slave  - the buffer itself
//           master - the environment (multiplier + consumer)
interface tt_um_result_buffer_if #(
  parameter int BitWidth = 8,
  parameter int RowW     = 3
);
  logic                       in_valid;
  logic [RowW-1:0]            in_row;
  logic signed [BitWidth-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [BitWidth-1:0] out_data;
  logic [RowW-1:0]            out_row;
  logic                       out_last;
  logic [RowW-1:0]            out_argmax;
  logic                       clr_flags;
  logic                       ovf;
  logic                       seq_err;

  modport slave (
    input  in_valid, in_row, in_data, out_ready, clr_flags,
    output out_valid, out_data, out_row, out_last, out_argmax, ovf, seq_err
  );

  modport master (
    output in_valid, in_row, in_data, out_ready, clr_flags,
    input  out_valid, out_data, out_row, out_last, out_argmax, ovf, seq_err
  );
endinterface

// File: rtl/tt_um_result_buffer.sv
// Ping-pong result buffer behind the ternary matrix-vector multiplier.
// Purpose : collects OutLen signed result bytes (one row per cycle) into a
//           frame, tracks the frame's argmax while filling, and drains full
//           frames through a valid/ready byte stream while the other bank fills.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset, discards all buffered data
//           bus   - tt_um_result_buffer_if.slave (fill input, drain stream, flags)
module tt_um_result_buffer #(
  parameter int OutLen   = 7,
  parameter int BitWidth = 8,
  parameter int RowW     = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  tt_um_result_buffer_if.slave  bus
);

  localparam logic [RowW-1:0] LastRow = RowW'(OutLen - 1);

  typedef enum logic [1:0] {IDLE, FILL, DROP} fill_state_t;

  fill_state_t                state_q, state_d;
  logic                       fill_ptr_q, fill_ptr_d;
  logic                       rd_ptr_q;
  logic [1:0]                 full_q, full_d;
  logic [RowW-1:0]            exp_q, exp_d;
  logic [RowW-1:0]            arg_q, arg_d;
  logic [RowW-1:0]            bank_arg_q [2];
  logic [RowW-1:0]            rd_idx_q;
  logic signed [BitWidth-1:0] max_q, max_d;
  logic signed [BitWidth-1:0] mem [2][OutLen];
  logic                       ovf_q, seq_q;

  logic wr_en, start, complete, ovf_set, seq_set;
  logic row0, out_valid, xfer, rd_last;

  assign row0      = (bus.in_row == '0);
  assign out_valid = full_q[rd_ptr_q];
  assign rd_last   = (rd_idx_q == LastRow);
  assign xfer      = out_valid & bus.out_ready;

  // Fill-side next state. A row 0 from any state funnels into 'start', which
  // either opens a frame in the fill bank or, if that bank has not drained yet,
  // drops the whole incoming frame.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    max_d      = max_q;
    arg_d      = arg_q;
    fill_ptr_d = fill_ptr_q;
    wr_en      = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    ovf_set    = 1'b0;
    seq_set    = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (row0) begin
            start = 1'b1;
          end else begin
            seq_set = 1'b1;
            state_d = DROP;
          end
        end
        FILL: begin
          if (row0) begin
            seq_set = 1'b1;
            start   = 1'b1;
          end else if (bus.in_row == exp_q) begin
            wr_en = 1'b1;
            // Strict compare: ties keep the earlier (lower) row index.
            if (bus.in_data > max_q) begin
              max_d = bus.in_data;
              arg_d = bus.in_row;
            end
            if (bus.in_row == LastRow) begin
              complete   = 1'b1;
              fill_ptr_d = ~fill_ptr_q;
              state_d    = IDLE;
            end else begin
              exp_d = exp_q + RowW'(1);
            end
          end else begin
            // Rows beyond OutLen-1 never match exp_q and land here too.
            seq_set = 1'b1;
            state_d = DROP;
          end
        end
        DROP: begin
          if (row0) start = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        if (full_q[fill_ptr_q]) begin
          ovf_set = 1'b1;
          state_d = DROP;
        end else begin
          wr_en   = 1'b1;
          max_d   = bus.in_data;
          arg_d   = '0;
          exp_d   = RowW'(1);
          state_d = FILL;
        end
      end
    end
  end

  // Bank occupancy: the fill side only completes into an empty bank and the
  // drain side only frees a full one, so set and clear never hit the same bank.
  always_comb begin
    full_d = full_q;
    if (complete) full_d[fill_ptr_q] = 1'b1;
    if (xfer && rd_last) full_d[rd_ptr_q] = 1'b0;
  end

  // Control state register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fill_ptr_q    <= 1'b0;
      rd_ptr_q      <= 1'b0;
      full_q        <= '0;
      exp_q         <= '0;
      arg_q         <= '0;
      bank_arg_q[0] <= '0;
      bank_arg_q[1] <= '0;
      rd_idx_q      <= '0;
      ovf_q         <= 1'b0;
      seq_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      full_q     <= full_d;
      exp_q      <= exp_d;
      arg_q      <= arg_d;
      if (complete) bank_arg_q[fill_ptr_q] <= arg_d;
      if (xfer) begin
        if (rd_last) begin
          rd_idx_q <= '0;
          rd_ptr_q <= ~rd_ptr_q;
        end else begin
          rd_idx_q <= rd_idx_q + RowW'(1);
        end
      end
      // A set in the same cycle as the clear wins.
      ovf_q <= (ovf_q & ~bus.clr_flags) | ovf_set;
      seq_q <= (seq_q & ~bus.clr_flags) | seq_set;
    end
  end

  // Data storage stage: element banks and running maximum, no reset needed.
  always_ff @(posedge clk) begin
    max_q <= max_d;
    if (wr_en) mem[fill_ptr_q][bus.in_row] <= bus.in_data;
  end

  // Bank contents are unreset, so the data output is forced to zero when idle.
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? mem[rd_ptr_q][rd_idx_q] : '0;
  assign bus.out_row    = rd_idx_q;
  assign bus.out_last   = rd_last;
  assign bus.out_argmax = bank_arg_q[rd_ptr_q];
  assign bus.ovf        = ovf_q;
  assign bus.seq_err    = seq_q;

endmodule

// File: tb/tb_tt_um_result_buffer.sv
// Testbench for tt_um_result_buffer: directed frames, expected bytes queued by
// the stimulus process and consumed by an independent output monitor.
module tb_tt_um_result_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_um_result_buffer_if #(.BitWidth(8), .RowW(3)) bif ();

  tt_um_result_buffer #(.OutLen(7), .BitWidth(8), .RowW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    int data;
    int row;
    int last;
    int arg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Output monitor: pops on every transfer, and checks the outputs are frozen
  // across each stall cycle.
  logic hold_v = 1'b0;
  int   hold_data, hold_row, hold_arg;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bif.out_valid) begin
        chk("stall_data", int'(bif.out_data), hold_data);
        chk("stall_row", int'(bif.out_row), hold_row);
        chk("stall_argmax", int'(bif.out_argmax), hold_arg);
      end
      if (bif.out_valid && bif.out_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(bif.out_data), e.data);
          chk("out_row", int'(bif.out_row), e.row);
          chk("out_last", int'(bif.out_last), e.last);
          chk("out_argmax", int'(bif.out_argmax), e.arg);
        end
      end else if (bif.out_valid) begin
        hold_v    = 1'b1;
        hold_data = int'(bif.out_data);
        hold_row  = int'(bif.out_row);
        hold_arg  = int'(bif.out_argmax);
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send(input int row, input int data);
    bif.in_valid = 1'b1;
    bif.in_row   = 3'(row);
    bif.in_data  = 8'(data);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int d[7]);
    for (int i = 0; i < 7; i++) send(i, d[i]);
  endtask

  task automatic push_frame(input int d[7], input int arg);
    for (int i = 0; i < 7; i++) exp_q.push_back('{d[i], i, (i == 6) ? 1 : 0, arg});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !bif.out_valid) break;
      @(posedge clk);
      #1;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_idle"}, int'(bif.out_valid), 0);
  endtask

  task automatic clear_flags();
    bif.clr_flags = 1'b1;
    @(posedge clk);
    #1;
    bif.clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr[7];
    int pat[4];

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_row    = '0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;
    bif.clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bif.out_valid), 0);
    chk("rst_out_data", int'(bif.out_data), 0);
    chk("rst_out_row", int'(bif.out_row), 0);
    chk("rst_out_last", int'(bif.out_last), 0);
    chk("rst_out_argmax", int'(bif.out_argmax), 0);
    chk("rst_ovf", int'(bif.ovf), 0);
    chk("rst_seq_err", int'(bif.seq_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with a tie at the maximum: latency and argmax.
    bif.out_ready = 1'b1;
    fr = '{5, -3, 127, -128, 127, 0, 1};
    push_frame(fr, 2);
    for (int i = 0; i < 6; i++) send(i, fr[i]);
    chk("t1_valid_before_last", int'(bif.out_valid), 0);
    send(6, fr[6]);
    chk("t1_valid_after_last", int'(bif.out_valid), 1);
    wait_drain("t1");

    // Two frames held back, third dropped on overflow, then gapless drain.
    bif.out_ready = 1'b0;
    fr = '{10, 20, 30, 40, 50, 60, 70};
    push_frame(fr, 6);
    send_frame(fr);
    fr = '{-1, -2, -3, -4, -5, -6, -7};
    push_frame(fr, 0);
    send_frame(fr);
    send(0, 99);
    chk("t2_ovf", int'(bif.ovf), 1);
    for (int i = 1; i < 7; i++) send(i, 99);
    bif.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("t2_no_gap", int'(bif.out_valid), 1);
      @(posedge clk);
      #1;
    end
    chk("t2_valid_after", int'(bif.out_valid), 0);
    chk("t2_pending", exp_q.size(), 0);
    clear_flags();
    chk("t2_ovf_cleared", int'(bif.ovf), 0);

    // Out-of-order row: partial frame discarded, next full frame delivered.
    send(0, 1);
    send(1, 2);
    send(3, 3);
    chk("t3_seq_err", int'(bif.seq_err), 1);
    send(4, 4);
    send(5, 5);
    chk("t3_no_output", int'(bif.out_valid), 0);
    fr = '{0, -1, -2, 3, 3, -100, 2};
    push_frame(fr, 3);
    send_frame(fr);
    wait_drain("t3");
    clear_flags();
    chk("t3_seq_cleared", int'(bif.seq_err), 0);

    // Consumer stalls in a 1,0,0,1 pattern.
    bif.out_ready = 1'b0;
    fr = '{7, 6, 5, 4, 3, 2, 1};
    push_frame(fr, 0);
    send_frame(fr);
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < 100; i++) begin
      bif.out_ready = pat[i % 4][0];
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bif.out_valid) break;
    end
    bif.out_ready = 1'b1;
    wait_drain("t4");

    // Asynchronous reset mid-drain with a flag set.
    bif.out_ready = 1'b0;
    fr = '{1, 2, 3, 4, 5, 6, 7};
    push_frame(fr, 6);
    send_frame(fr);
    send(0, 9);
    send(5, 9);
    chk("t5_seq_err", int'(bif.seq_err), 1);
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(bif.out_valid), 0);
    chk("t5_rst_data", int'(bif.out_data), 0);
    chk("t5_rst_seq_err", int'(bif.seq_err), 0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fr = '{-5, -4, -3, -2, -1, -6, -7};
    push_frame(fr, 4);
    send_frame(fr);
    wait_drain("t5");

    // Overflow in the same cycle as clr_flags, then clr_flags alone.
    bif.out_ready = 1'b0;
    fr = '{-128, -128, -127, 0, 0, 0, 0};
    push_frame(fr, 3);
    send_frame(fr);
    fr = '{0, 0, 0, 0, 0, 0, 0};
    push_frame(fr, 0);
    send_frame(fr);
    bif.clr_flags = 1'b1;
    send(0, 55);
    chk("t6_set_wins", int'(bif.ovf), 1);
    @(posedge clk);
    #1;
    bif.clr_flags = 1'b0;
    chk("t6_cleared", int'(bif.ovf), 0);
    bif.out_ready = 1'b1;
    wait_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_result_buffer.md
Name: tt_um_result_buffer

Overview:
- Output collector placed directly downstream of the ternary matrix-vector multiplier.
- Captures the OutLen signed result bytes the multiplier emits one row per cycle during MULT, and assembles them into a frame.
- Ping-pong double buffer: the next frame fills while the previous one drains.
- Drains through a valid/ready byte stream, and reports the frame's argmax index plus sticky overflow and sequence-error flags.

Parameters:
- OutLen, 7, rows per result frame (one byte per row).
- BitWidth, 8, width of each signed result element.
- RowW, 3, width of the row index; must satisfy 2^RowW >= OutLen.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  multiplier is in MULT and in_data/in_row are meaningful.
- in_row  in  RowW  row index of in_data.
- in_data  in  BitWidth  signed result element for in_row.
- out_valid  out  1  out_data holds a buffered element.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  BitWidth  element at read index of the draining bank.
- out_row  out  RowW  row index of out_data.
- out_last  out  1  out_data is the frame's final element (out_row == OutLen-1).
- out_argmax  out  RowW  index of the largest signed element of the draining frame; stable while out_valid.
- clr_flags  in  1  synchronous clear of the sticky flags.
- ovf  out  1  sticky: a frame was dropped because the fill bank was still full.
- seq_err  out  1  sticky: an out-of-order row was received.

Behaviour:
- Reset (async, rst_n=0):
  - both banks empty; fill pointer, read pointer, expected row and read index = 0; flags = 0.
  - out_valid=0, out_data=0, out_row=0, out_last=0, out_argmax=0, ovf=0, seq_err=0.
  - Reset mid-frame or mid-drain discards all buffered data.
- Fill-side states per fill bank: IDLE (expect row 0), FILL (expect row k), DROP (discard until next row 0).
  - in_valid=0: nothing changes; a partial frame holds its position (no error).
  - in_valid=1, in_row=0, fill bank empty: write element 0, argmax = 0, max = in_data, expect 1, go to FILL.
  - in_valid=1, in_row=0, fill bank full (registered flag at that edge, even if it is freed the same cycle): set ovf, go to DROP, write nothing.
  - FILL, in_row == expected: write element; if in_data > max (signed, strict), update max and argmax, so ties keep the lowest index.
  - On in_row == OutLen-1: mark bank full, latch argmax with the bank, toggle fill pointer, go to IDLE.
  - FILL, in_row != expected and != 0: set seq_err, discard the partial frame (bank stays empty), go to DROP.
  - FILL, in_row == 0: set seq_err and restart the frame at row 0 (same handling as IDLE with row 0).
  - in_row >= OutLen: treated as out-of-order.
  - DROP: ignore everything until in_row=0 arrives, then handle as IDLE with row 0.
- Drain side:
  - out_valid = read bank full.
  - out_data = bank[read index]; out_row = read index; out_last = (read index == OutLen-1).
  - Transfer on out_valid & out_ready: read index increments.
  - Transfer with out_last: bank marked empty, read index = 0, read pointer toggles.
  - With the other bank already full, out_valid stays 1 on the next cycle (back-to-back frames, no bubble).
  - out_valid rises the cycle after the edge that writes row OutLen-1 (latency 1).
  - Minimum cycles per frame: OutLen in, OutLen out.
  - out_data, out_row and out_argmax are held stable while out_valid=1 and out_ready=0.
- Flags:
  - clr_flags=1 clears ovf and seq_err at the edge.
  - A set event in the same cycle as clr_flags wins (flag ends at 1).
- Arithmetic: all comparisons are BitWidth two's-complement signed; no arithmetic is performed on the data.

Test Plan:
- Rows 0..6 with data 5,-3,127,-128,127,0,1, out_ready=1 -> out_valid high at cycle 8; bytes stream in order; out_last on row 6; out_argmax=2 (tie with row 4 keeps lowest).
- Two frames back-to-back with out_ready=0, then a third frame at row 0 -> ovf=1, third frame dropped; release ready -> 14 bytes drain with no gap; out_valid then 0.
- Rows 0,1,3 -> seq_err=1, rows ignored until row 0; then a full frame 0..6 -> exactly that frame delivered.
- out_ready toggling 1,0,0,1 during a drain -> each byte appears once; data, row and argmax held during stalls.
- Assert rst_n=0 asynchronously mid-drain (between clock edges) -> out_valid=0 immediately, flags cleared, next frame delivered cleanly.
- clr_flags asserted in the same cycle as an overflow event -> ovf stays 1; clr_flags alone on the next cycle -> ovf=0.
